// File: rtl/div_unit_32bit.sv
// ----------------------------------------------------------------------------
// div_unit_32bit
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   Fixed latency: START accepted on edge n -> DONE high in the cycle after
//   edge n+34, regardless of operand values.
//
// Ports
//   CLK       in   1      rising-edge clock
//   RST       in   1      synchronous, active-high reset
//   START     in   1      request; sampled when not BUSY (IDLE or FIN)
//   FLUSH     in   1      abort any in-flight op; wins over START
//   OP        in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   DIVIDEND  in   32     rs1
//   DIVISOR   in   32     rs2
//   BUSY      out  1      op in flight (RUN/FIX)
//   DONE      out  1      one-cycle pulse, RESULT valid
//   RESULT    out  32     quotient or remainder, held until next DONE
// ----------------------------------------------------------------------------
module div_unit_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             FLUSH,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvsr;
    logic             is_rem;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic             ovf;

    logic             accept;
    logic             is_signed;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] fix_val;

    assign accept = ((state == IDLE) || (state == FIN)) && START && !FLUSH;
    assign BUSY   = (state == RUN) || (state == FIX);
    assign DONE   = (state == FIN);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? RUN : IDLE;
            // cnt reaches 32 after the last step; one more RUN cycle keeps the
            // overall latency at 34 edges.
            RUN:     state_nxt = (cnt == 6'd32) ? FIX : RUN;
            FIX:     state_nxt = FIN;
            FIN:     state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (FLUSH) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand preparation
    always_comb begin
        is_signed    = !OP[0];
        dividend_abs = (is_signed && DIVIDEND[WIDTH-1]) ? -DIVIDEND : DIVIDEND;
        divisor_abs  = (is_signed && DIVISOR[WIDTH-1])  ? -DIVISOR  : DIVISOR;
    end

    // One restoring step; the shift keeps the bit leaving rem so the trial
    // compare is a true 33-bit compare even for divisors >= 2^31.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr};
    end

    // Sign correction and special-case selection
    always_comb begin
        q_fix = neg_q ? -quo : quo;
        r_fix = neg_r ? -rem : rem;
        if (div_zero) begin
            // remainder of x/0 restores to x naturally after sign correction
            fix_val = is_rem ? r_fix : '1;
        end else if (ovf) begin
            fix_val = is_rem ? '0 : MIN_INT;
        end else begin
            fix_val = is_rem ? r_fix : q_fix;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            RESULT   <= '0;
        end else begin
            if (accept) begin
                cnt      <= '0;
                quo      <= dividend_abs;
                rem      <= '0;
                dvsr     <= divisor_abs;
                is_rem   <= OP[1];
                neg_q    <= is_signed && (DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1]);
                neg_r    <= is_signed && DIVIDEND[WIDTH-1];
                div_zero <= (DIVISOR == '0);
                ovf      <= is_signed && (DIVIDEND == MIN_INT) && (DIVISOR == '1);
            end else if ((state == RUN) && !cnt[5]) begin
                cnt <= cnt + 6'd1;
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end
            if ((state == FIX) && !FLUSH) begin
                RESULT <= fix_val;
            end
        end
    end

endmodule

// File: tb/tb_div_unit_32bit.sv
module tb_div_unit_32bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    div_unit_32bit #(.WIDTH(32)) dut (
        .CLK      (clk),
        .RST      (rst),
        .START    (start),
        .FLUSH    (flush),
        .OP       (op),
        .DIVIDEND (dividend),
        .DIVISOR  (divisor),
        .BUSY     (busy),
        .DONE     (done),
        .RESULT   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    // RISC-V M-extension semantics in plain arithmetic
    function automatic logic [31:0] ref_div(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ends #1 after the accepting edge.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Returns the number of edges until DONE is seen (-1 on timeout).
    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = -1;
        res = '0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                res = result;
                return;
            end
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    vec_t        vecs[$];
    int          lat;
    int          lat2;
    int          n;
    logic [31:0] res;
    logic [31:0] old_res;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  o;
    int          sel;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);

        vecs.push_back('{2'b01, 32'd100, 32'd7, 32'd14});
        vecs.push_back('{2'b11, 32'd100, 32'd7, 32'd2});
        vecs.push_back('{2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD});
        vecs.push_back('{2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 32'd7, -32'sd2, 32'd1});
        vecs.push_back('{2'b00, 32'd12345, 32'd0, 32'hFFFF_FFFF});
        vecs.push_back('{2'b01, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234});
        vecs.push_back('{2'b10, -32'sd5, 32'd0, -32'sd5});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF});
        vecs.push_back('{2'b00, -32'sd100, -32'sd7, 32'd14});

        foreach (vecs[i]) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, res);
            check($sformatf("vec%0d_latency", i), lat, 32'd34);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
        end

        // Pulse is one cycle wide
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // START during RUN is ignored
        launch(2'b01, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        op = 2'b01; dividend = 32'd999; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("run_start_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, res);
        check("run_start_latency", lat + 6, 32'd34);
        check("run_start_result", res, 32'd14);
        count_done(40, n);
        check("run_start_extra_done", n, 32'd0);

        // FLUSH at cycle 10 of RUN
        old_res = result;
        launch(2'b00, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        count_done(40, n);
        check("flush_no_done", n, 32'd0);
        check("flush_result_held", result, old_res);
        launch(2'b00, 32'd1000, 32'd3);
        wait_done(lat, res);
        check("post_flush_latency", lat, 32'd34);
        check("post_flush_result", res, 32'd333);

        // RST at cycle 20
        launch(2'b01, 32'd77, 32'd5);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        count_done(40, n);
        check("rst_mid_no_done", n, 32'd0);

        // Back-to-back START during FIN
        launch(2'b01, 32'd50, 32'd6);
        wait_done(lat, res);
        check("b2b_first_result", res, 32'd8);
        op = 2'b11; dividend = 32'd50; divisor = 32'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_done_drop", {31'd0, done}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(lat2, res);
        check("b2b_second_latency", lat2, 32'd34);
        check("b2b_second_result", res, 32'd2);

        // Random ops against the reference
        for (int i = 0; i < 1200; i++) begin
            o   = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = $urandom_range(1, 15);
            else if (sel == 3) b = b >> $urandom_range(0, 31);
            launch(o, a, b);
            wait_done(lat, res);
            if (lat != 34) check($sformatf("rand%0d_latency", i), lat, 32'd34);
            check($sformatf("rand%0d_op%0d_%h_%h", i, o, a, b), res, ref_div(o, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
